// File: rtl/arr_drv_pkg.sv
// Shared types and constants for the arr equality-checker stimulus driver.
// Used by arr_drv and arr_drv_pattern; the LFSR polynomial only matters when ARR_DRV_LFSR_EN is defined.
package arr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arr_drv_state_e;

    localparam logic [31:0] ARR_DRV_LFSR_POLY_C = 32'h8020_0003;
    localparam logic [0:0]  ARR_DRV_INJ_MASK_C  = 1'b1;

endpackage

// File: rtl/arr_drv_pattern.sv
// Combinational vector generator for arr_drv: first vector from the seed, next vector from the current one.
// Build option ARR_DRV_LFSR_EN swaps the incrementing pattern for a 32-bit Galois LFSR.
module arr_drv_pattern
    import arr_drv_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH-1:0] vec_cur,
    input  logic [31:0]       lfsr_cur,
    input  logic [LENGTH-1:0] seed,
    output logic [LENGTH-1:0] vec_first,
    output logic [31:0]       lfsr_first,
    output logic [LENGTH-1:0] vec_nxt,
    output logic [31:0]       lfsr_nxt
);

`ifdef ARR_DRV_LFSR_EN
    function automatic logic [31:0] widen(input logic [LENGTH-1:0] v);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = v[i % LENGTH];
        return w;
    endfunction

    function automatic logic [LENGTH-1:0] narrow(input logic [31:0] l);
        logic [LENGTH-1:0] r;
        for (int i = 0; i < LENGTH; i++) r[i] = l[i % 32];
        return r;
    endfunction

    // Bit 0 of the polynomial is the constant term, carried by the feedback bit itself.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ ({32{l[0]}} & (ARR_DRV_LFSR_POLY_C & ~32'h1));
    endfunction

    always_comb begin
        lfsr_first = widen(seed) | 32'h1;
        vec_first  = narrow(lfsr_first);
        lfsr_nxt   = lfsr_step(lfsr_cur);
        vec_nxt    = narrow(lfsr_nxt);
    end
`else
    always_comb begin
        lfsr_first = '0;
        vec_first  = seed;
        lfsr_nxt   = lfsr_cur;
        vec_nxt    = vec_cur + LENGTH'(1);
    end
`endif

endmodule

// File: rtl/arr_drv.sv
// Burst driver for the arr equality checker: one sig0/sig1 pair per clock, optional single corrupted pair.
// Pattern source selected by ARR_DRV_LFSR_EN inside arr_drv_pattern; FSM and counters live here.
module arr_drv
    import arr_drv_pkg::*;
#(
    parameter int LENGTH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              arr_drv_clk_ip,
    input  logic              arr_drv_rst_ip,
    input  logic              arr_drv_start_ip,
    input  logic [CNT_W-1:0]  arr_drv_count_ip,
    input  logic [CNT_W-1:0]  arr_drv_inject_ip,
    input  logic [LENGTH-1:0] arr_drv_seed_ip,
    output logic [LENGTH-1:0] arr_drv_sig0_op,
    output logic [LENGTH-1:0] arr_drv_sig1_op,
    output logic              arr_drv_expect_err_op,
    output logic              arr_drv_busy_op,
    output logic              arr_drv_done_op,
    output logic [CNT_W-1:0]  arr_drv_sent_op
);

    localparam logic [LENGTH-1:0] INJ_MASK = LENGTH'(ARR_DRV_INJ_MASK_C);

    arr_drv_state_e    state_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic [CNT_W-1:0]  inj_p1;
    logic [CNT_W-1:0]  sent_p1;
    logic [LENGTH-1:0] sig0_p1;
    logic [LENGTH-1:0] sig1_p1;
    logic [31:0]       lfsr_p1;
    logic              err_p1;
    logic              vld_p1;
    logic              done_p1;

    logic [LENGTH-1:0] vec_first;
    logic [LENGTH-1:0] vec_nxt;
    logic [31:0]       lfsr_first;
    logic [31:0]       lfsr_nxt;
    logic [CNT_W-1:0]  sent_inc;
    logic              hit_first;
    logic              hit_nxt;

    arr_drv_pattern #(.LENGTH(LENGTH)) u_pattern (
        .vec_cur    (sig0_p1),
        .lfsr_cur   (lfsr_p1),
        .seed       (arr_drv_seed_ip),
        .vec_first  (vec_first),
        .lfsr_first (lfsr_first),
        .vec_nxt    (vec_nxt),
        .lfsr_nxt   (lfsr_nxt)
    );

    // Index 0 never matches a 1-based vector number, so inject == 0 disables corruption for free.
    assign sent_inc  = sent_p1 + CNT_W'(1);
    assign hit_first = (arr_drv_inject_ip == CNT_W'(1));
    assign hit_nxt   = (sent_inc == inj_p1);

    // Stage p1: FSM, counters and registered outputs
    always_ff @(posedge arr_drv_clk_ip or posedge arr_drv_rst_ip) begin
        if (arr_drv_rst_ip) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
            inj_p1   <= '0;
            sent_p1  <= '0;
            sig0_p1  <= '0;
            sig1_p1  <= '0;
            lfsr_p1  <= '0;
            err_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            case (state_p1)
                IDLE: begin
                    done_p1 <= 1'b0;
                    if (arr_drv_start_ip) begin
                        if (arr_drv_count_ip != '0) begin
                            state_p1 <= RUN;
                            cnt_p1   <= arr_drv_count_ip;
                            inj_p1   <= arr_drv_inject_ip;
                            sent_p1  <= CNT_W'(1);
                            sig0_p1  <= vec_first;
                            sig1_p1  <= vec_first ^ (hit_first ? INJ_MASK : '0);
                            lfsr_p1  <= lfsr_first;
                            err_p1   <= hit_first;
                            vld_p1   <= 1'b1;
                        end else begin
                            state_p1 <= DONE;
                            sent_p1  <= '0;
                            done_p1  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Comparing before incrementing keeps sent within count, so a full-scale count cannot wrap.
                    if (sent_p1 == cnt_p1) begin
                        state_p1 <= DONE;
                        sig0_p1  <= '0;
                        sig1_p1  <= '0;
                        err_p1   <= 1'b0;
                        vld_p1   <= 1'b0;
                        done_p1  <= 1'b1;
                    end else begin
                        sent_p1  <= sent_inc;
                        sig0_p1  <= vec_nxt;
                        sig1_p1  <= vec_nxt ^ (hit_nxt ? INJ_MASK : '0);
                        lfsr_p1  <= lfsr_nxt;
                        err_p1   <= hit_nxt;
                    end
                end
                DONE: begin
                    state_p1 <= IDLE;
                    done_p1  <= 1'b0;
                end
                default: begin
                    state_p1 <= IDLE;
                end
            endcase
        end
    end

    assign arr_drv_sig0_op       = sig0_p1;
    assign arr_drv_sig1_op       = sig1_p1;
    assign arr_drv_expect_err_op = err_p1;
    assign arr_drv_busy_op       = vld_p1;
    assign arr_drv_done_op       = done_p1;
    assign arr_drv_sent_op       = sent_p1;

endmodule

// File: tb/tb_arr_drv.sv
// Scoreboard bench for arr_drv: expected pairs and done pulses are queued at stimulus time, monitors pop and compare.
// With ARR_DRV_LFSR_EN defined only the reset checks and the 32-bit LFSR sequence are exercised.
module tb_arr_drv;

`ifdef ARR_DRV_LFSR_EN
    localparam int LB = 32;
`else
    localparam int LB = 1;
`endif

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic        err;
        logic [15:0] sent;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // instance a: LENGTH=8, CNT_W=16
    logic        start_a;
    logic [15:0] count_a, inject_a, sent_a;
    logic [7:0]  seed_a, sig0_a, sig1_a;
    logic        err_a, busy_a, done_a;
    // instance b: LENGTH=LB
    logic          start_b;
    logic [15:0]   count_b, inject_b, sent_b;
    logic [LB-1:0] seed_b, sig0_b, sig1_b;
    logic          err_b, busy_b, done_b;
    // instance c: LENGTH=8, CNT_W=4 (full-scale count)
    logic       start_c;
    logic [3:0] count_c, inject_c, sent_c;
    logic [7:0] seed_c, sig0_c, sig1_c;
    logic       err_c, busy_c, done_c;

    exp_t        q_a[$], q_b[$], q_c[$];
    logic [15:0] d_a[$], d_b[$], d_c[$];
    exp_t        e_a, e_b, e_c;
    logic [15:0] ds_a, ds_b, ds_c;

    int n_cmp = 0;
    int n_bad = 0;

    arr_drv #(.LENGTH(8), .CNT_W(16)) u_dut_a (
        .arr_drv_clk_ip(clk), .arr_drv_rst_ip(rst), .arr_drv_start_ip(start_a),
        .arr_drv_count_ip(count_a), .arr_drv_inject_ip(inject_a), .arr_drv_seed_ip(seed_a),
        .arr_drv_sig0_op(sig0_a), .arr_drv_sig1_op(sig1_a), .arr_drv_expect_err_op(err_a),
        .arr_drv_busy_op(busy_a), .arr_drv_done_op(done_a), .arr_drv_sent_op(sent_a));

    arr_drv #(.LENGTH(LB), .CNT_W(16)) u_dut_b (
        .arr_drv_clk_ip(clk), .arr_drv_rst_ip(rst), .arr_drv_start_ip(start_b),
        .arr_drv_count_ip(count_b), .arr_drv_inject_ip(inject_b), .arr_drv_seed_ip(seed_b),
        .arr_drv_sig0_op(sig0_b), .arr_drv_sig1_op(sig1_b), .arr_drv_expect_err_op(err_b),
        .arr_drv_busy_op(busy_b), .arr_drv_done_op(done_b), .arr_drv_sent_op(sent_b));

    arr_drv #(.LENGTH(8), .CNT_W(4)) u_dut_c (
        .arr_drv_clk_ip(clk), .arr_drv_rst_ip(rst), .arr_drv_start_ip(start_c),
        .arr_drv_count_ip(count_c), .arr_drv_inject_ip(inject_c), .arr_drv_seed_ip(seed_c),
        .arr_drv_sig0_op(sig0_c), .arr_drv_sig1_op(sig1_c), .arr_drv_expect_err_op(err_c),
        .arr_drv_busy_op(busy_c), .arr_drv_done_op(done_c), .arr_drv_sent_op(sent_c));

    function automatic exp_t mk(input logic [31:0] s0, input logic [31:0] s1,
                                input logic err, input logic [15:0] sent);
        exp_t e;
        e.s0 = s0; e.s1 = s1; e.err = err; e.sent = sent;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic unexp(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT presented an output with nothing expected", nm);
    endtask

    // Monitors: every busy cycle consumes one expected pair, every done pulse one expected end-of-burst.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_a) begin
                if (q_a.size() == 0) unexp("a_vec");
                else begin
                    e_a = q_a.pop_front();
                    cmp("a_vec", {24'd0, sig0_a, 24'd0, sig1_a, 15'd0, err_a, sent_a},
                        {e_a.s0, e_a.s1, 15'd0, e_a.err, e_a.sent});
                end
            end
            if (done_a) begin
                if (d_a.size() == 0) unexp("a_done");
                else begin
                    ds_a = d_a.pop_front();
                    cmp("a_done", 96'({busy_a, err_a, sig0_a, sig1_a, sent_a}),
                        96'({1'b0, 1'b0, 8'd0, 8'd0, ds_a}));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy_b) begin
                if (q_b.size() == 0) unexp("b_vec");
                else begin
                    e_b = q_b.pop_front();
                    cmp("b_vec", {32'(sig0_b), 32'(sig1_b), 15'd0, err_b, sent_b},
                        {e_b.s0, e_b.s1, 15'd0, e_b.err, e_b.sent});
                end
            end
            if (done_b) begin
                if (d_b.size() == 0) unexp("b_done");
                else begin
                    ds_b = d_b.pop_front();
                    cmp("b_done", 96'({busy_b, err_b, 32'(sig0_b), 32'(sig1_b), sent_b}),
                        96'({1'b0, 1'b0, 32'd0, 32'd0, ds_b}));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy_c) begin
                if (q_c.size() == 0) unexp("c_vec");
                else begin
                    e_c = q_c.pop_front();
                    cmp("c_vec", {24'd0, sig0_c, 24'd0, sig1_c, 15'd0, err_c, 12'd0, sent_c},
                        {e_c.s0, e_c.s1, 15'd0, e_c.err, e_c.sent});
                end
            end
            if (done_c) begin
                if (d_c.size() == 0) unexp("c_done");
                else begin
                    ds_c = d_c.pop_front();
                    cmp("c_done", 96'({busy_c, err_c, sig0_c, sig1_c, 12'd0, sent_c}),
                        96'({1'b0, 1'b0, 8'd0, 8'd0, ds_c}));
                end
            end
        end
    end

    task automatic start_a_t(input logic [7:0] seed, input logic [15:0] cnt, input logic [15:0] inj);
        @(negedge clk);
        seed_a = seed; count_a = cnt; inject_a = inj; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int left;
        left = budget;
        while ((q_a.size() + q_b.size() + q_c.size() + d_a.size() + d_b.size() + d_c.size()) != 0
               && left > 0) begin
            @(negedge clk);
            left--;
        end
        repeat (3) @(negedge clk);
        cmp(nm, 96'(q_a.size() + q_b.size() + q_c.size() + d_a.size() + d_b.size() + d_c.size()), 96'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; count_a = '0; inject_a = '0; seed_a = '0;
        start_b = 1'b0; count_b = '0; inject_b = '0; seed_b = '0;
        start_c = 1'b0; count_c = '0; inject_c = '0; seed_c = '0;
        repeat (3) @(negedge clk);
        cmp("reset_a", 96'({sig0_a, sig1_a, err_a, busy_a, done_a, sent_a}), 96'd0);
        cmp("reset_b", 96'({32'(sig0_b), 32'(sig1_b), err_b, busy_b, done_b, sent_b}), 96'd0);
        cmp("reset_c", 96'({sig0_c, sig1_c, err_c, busy_c, done_c, sent_c}), 96'd0);
        rst = 1'b0;
        @(negedge clk);
        cmp("idle_after_reset_a", 96'({sig0_a, sig1_a, busy_a, done_a, sent_a}), 96'd0);

`ifndef ARR_DRV_LFSR_EN
        // 1: wrap-around of the incrementing pattern
        q_a.push_back(mk(32'hFE, 32'hFE, 1'b0, 16'd1));
        q_a.push_back(mk(32'hFF, 32'hFF, 1'b0, 16'd2));
        q_a.push_back(mk(32'h00, 32'h00, 1'b0, 16'd3));
        q_a.push_back(mk(32'h01, 32'h01, 1'b0, 16'd4));
        d_a.push_back(16'd4);
        start_a_t(8'hFE, 16'd4, 16'd0);
        wait_drain("t1_drain", 50);
        cmp("t1_sent_hold", 96'(sent_a), 96'd4);

        // 2: single injected mismatch on vector 3
        q_a.push_back(mk(32'h10, 32'h10, 1'b0, 16'd1));
        q_a.push_back(mk(32'h11, 32'h11, 1'b0, 16'd2));
        q_a.push_back(mk(32'h12, 32'h13, 1'b1, 16'd3));
        q_a.push_back(mk(32'h13, 32'h13, 1'b0, 16'd4));
        q_a.push_back(mk(32'h14, 32'h14, 1'b0, 16'd5));
        d_a.push_back(16'd5);
        start_a_t(8'h10, 16'd5, 16'd3);
        wait_drain("t2_drain", 50);

        // 3: empty burst, done only; inject > count afterwards
        d_a.push_back(16'd0);
        start_a_t(8'h55, 16'd0, 16'd1);
        cmp("t3_done_next_cycle", 96'({done_a, busy_a, sig0_a, sig1_a}), 96'({1'b1, 1'b0, 8'd0, 8'd0}));
        wait_drain("t3_drain", 20);
        cmp("t3_sent_zero", 96'(sent_a), 96'd0);

        q_a.push_back(mk(32'hA0, 32'hA0, 1'b0, 16'd1));
        q_a.push_back(mk(32'hA1, 32'hA1, 1'b0, 16'd2));
        d_a.push_back(16'd2);
        start_a_t(8'hA0, 16'd2, 16'd7);
        wait_drain("t3b_drain", 20);

        // 4: start re-pulsed at vector 2, vector 6 and in DONE is ignored
        for (int n = 1; n <= 6; n++) q_a.push_back(mk(32'h2F + 32'(n), 32'h2F + 32'(n), 1'b0, 16'(n)));
        d_a.push_back(16'd6);
        start_a_t(8'h30, 16'd6, 16'd0);
        @(negedge clk);
        start_a = 1'b1; count_a = 16'd3;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        wait_drain("t4_drain", 30);

        // 5: asynchronous reset during vector 3 of 8, then a normal burst
        for (int n = 1; n <= 8; n++) q_a.push_back(mk(32'h3F + 32'(n), 32'h3F + 32'(n), 1'b0, 16'(n)));
        start_a_t(8'h40, 16'd8, 16'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 cmp("t5_async_clear", 96'({sig0_a, sig1_a, err_a, busy_a, done_a, sent_a}), 96'd0);
        q_a.delete();
        d_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp("t5_no_done", 96'({done_a, busy_a}), 96'd0);
        q_a.push_back(mk(32'h7F, 32'h7F, 1'b0, 16'd1));
        q_a.push_back(mk(32'h80, 32'h80, 1'b0, 16'd2));
        d_a.push_back(16'd2);
        start_a_t(8'h7F, 16'd2, 16'd0);
        wait_drain("t5_drain", 20);

        // full-scale count on a 4-bit counter, injection on the last vector
        for (int n = 1; n <= 15; n++)
            q_c.push_back(mk(32'(8'(8'hF7 + n)), 32'(8'(8'hF7 + n)) ^ ((n == 15) ? 32'h1 : 32'h0),
                             1'(n == 15), 16'(n)));
        d_c.push_back(16'd15);
        @(negedge clk);
        seed_c = 8'hF8; count_c = 4'd15; inject_c = 4'd15; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        wait_drain("tc_drain", 40);

        // 6: single-bit vector, injection on vector 2
        q_b.push_back(mk(32'h1, 32'h1, 1'b0, 16'd1));
        q_b.push_back(mk(32'h0, 32'h1, 1'b1, 16'd2));
        q_b.push_back(mk(32'h1, 32'h1, 1'b0, 16'd3));
        d_b.push_back(16'd3);
        @(negedge clk);
        seed_b = '1; count_b = 16'd3; inject_b = 16'd2; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_drain("t6_drain", 20);
`else
        // 6: LFSR pattern, 32-bit vector seeded with 1
        q_b.push_back(mk(32'h0000_0001, 32'h0000_0001, 1'b0, 16'd1));
        q_b.push_back(mk(32'h8020_0002, 32'h8020_0002, 1'b0, 16'd2));
        q_b.push_back(mk(32'h4010_0001, 32'h4010_0001, 1'b0, 16'd3));
        d_b.push_back(16'd3);
        @(negedge clk);
        seed_b = LB'(1); count_b = 16'd3; inject_b = 16'd0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_drain("t6_lfsr_drain", 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
